// File: rtl/arith_muli_pipe.sv
// Pipelined integer multiplier with joined valid/ready operand inputs and an elastic result output.
// Each stage holds the full double-width product; the output selects the low or high half.
module arith_muli_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3,
  parameter bit SIGNED = 1'b0,
  parameter bit HIGH   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_data,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result_data,
  output logic             busy
);

  localparam int PW = 2 * WIDTH;

  if (STAGES < 1) begin : g_bad_stages
    $error("arith_muli_pipe: STAGES must be at least 1");
  end

  logic [STAGES-1:0] v_reg;
  logic [STAGES-1:0] v_next;
  logic [PW-1:0]     p_reg  [STAGES];
  logic [PW-1:0]     p_next [STAGES];
  logic [STAGES-1:0] adv;
  logic [PW-1:0]     a_ext;
  logic [PW-1:0]     b_ext;
  logic [PW-1:0]     prod;
  logic              in_fire;

  // A stage may move when any slot from it to the output is empty or the output pops.
  // Written in closed form so adv has no self-referencing combinational chain.
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_adv
    assign adv[gi] = result_ready | ~(&v_reg[STAGES-1:gi]);
  end

  assign a_ready = adv[0] & b_valid;
  assign b_ready = adv[0] & a_valid;
  assign in_fire = a_valid & b_valid & adv[0];

  if (SIGNED) begin : g_sext
    assign a_ext = {{WIDTH{a_data[WIDTH-1]}}, a_data};
    assign b_ext = {{WIDTH{b_data[WIDTH-1]}}, b_data};
  end else begin : g_zext
    assign a_ext = {{WIDTH{1'b0}}, a_data};
    assign b_ext = {{WIDTH{1'b0}}, b_data};
  end

  // Truncating a PW x PW product to PW bits is exact for both encodings.
  assign prod = a_ext * b_ext;

  always_comb begin
    v_next = v_reg;
    p_next = p_reg;
    if (adv[0]) begin
      v_next[0] = in_fire;
      if (in_fire) begin
        p_next[0] = prod;
      end
    end
    for (int i = 1; i < STAGES; i++) begin
      if (adv[i]) begin
        v_next[i] = v_reg[i-1];
        p_next[i] = p_reg[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_reg <= '0;
      for (int i = 0; i < STAGES; i++) begin
        p_reg[i] <= '0;
      end
    end else begin
      v_reg <= v_next;
      for (int i = 0; i < STAGES; i++) begin
        p_reg[i] <= p_next[i];
      end
    end
  end

  assign result_valid = v_reg[STAGES-1];
  assign busy         = |v_reg;

  if (HIGH) begin : g_high
    assign result_data = p_reg[STAGES-1][PW-1:WIDTH];
  end else begin : g_low
    assign result_data = p_reg[STAGES-1][WIDTH-1:0];
  end

endmodule

// File: tb/tb_arith_muli_pipe.sv
// Self-checking bench: 32-bit pipes (unsigned-low and signed-high sharing handshakes)
// against a queue model, plus four 8-bit instances covering every signedness/half combination.
module tb_arith_muli_pipe;

  localparam int W = 32;
  localparam int S = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_valid, b_valid, result_ready;
  logic [W-1:0]  a_data, b_data;
  logic          a_ready, b_ready, result_valid, busy;
  logic [W-1:0]  result_data;
  logic          sh_a_ready, sh_b_ready, sh_result_valid, sh_busy;
  logic [W-1:0]  sh_result_data;

  logic          v8;
  logic [7:0]    a8, b8;
  logic          ar8 [4];
  logic          br8 [4];
  logic          rv8 [4];
  logic          busy8 [4];
  logic [7:0]    rd8 [4];

  always #5 clk = ~clk;

  arith_muli_pipe #(.WIDTH(W), .STAGES(S), .SIGNED(1'b0), .HIGH(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_data(result_data), .busy(busy)
  );

  arith_muli_pipe #(.WIDTH(W), .STAGES(S), .SIGNED(1'b1), .HIGH(1'b1)) dut_sh (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(sh_a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(sh_b_ready), .b_data(b_data),
    .result_valid(sh_result_valid), .result_ready(result_ready),
    .result_data(sh_result_data), .busy(sh_busy)
  );

  // Config k: SIGNED = k/2, HIGH = k%2.
  for (genvar gi = 0; gi < 4; gi++) begin : g_u8
    arith_muli_pipe #(.WIDTH(8), .STAGES(S), .SIGNED(gi / 2), .HIGH(gi % 2)) u8 (
      .clk(clk), .rst_n(rst_n),
      .a_valid(v8), .a_ready(ar8[gi]), .a_data(a8),
      .b_valid(v8), .b_ready(br8[gi]), .b_data(b8),
      .result_valid(rv8[gi]), .result_ready(1'b1),
      .result_data(rd8[gi]), .busy(busy8[gi])
    );
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           fire;
  } ent_t;

  ent_t q[$];
  int   cyc = 0;
  int   last_pop = -100;
  int   checks = 0;
  int   errors = 0;
  int   dut_fires = 0;
  int   dut_pops = 0;
  bit   m_fire;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] lo_u(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    return p[31:0];
  endfunction

  function automatic logic [W-1:0] hi_s(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[63:32];
  endfunction

  function automatic logic [7:0] ref8(input int k, input logic [7:0] a, input logic [7:0] b);
    int p;
    if (k / 2 == 1) p = int'($signed(a)) * int'($signed(b));
    else            p = int'(a) * int'(b);
    return (k % 2 == 1) ? p[15:8] : p[7:0];
  endfunction

  // One clock cycle: check outputs mid-cycle against the model, then advance to just past the edge.
  task automatic step();
    bit adv0, exp_valid;
    int arr;
    @(negedge clk);
    m_fire = 1'b0;
    if (rst_n) begin
      adv0 = (q.size() < S) || result_ready;
      exp_valid = 1'b0;
      if (q.size() > 0) begin
        arr = (q[0].fire + S > last_pop + 1) ? q[0].fire + S : last_pop + 1;
        exp_valid = (arr <= cyc);
      end
      chk("result_valid", {63'b0, result_valid}, {63'b0, exp_valid});
      chk("busy", {63'b0, busy}, {63'b0, q.size() > 0});
      chk("a_ready", {63'b0, a_ready}, {63'b0, adv0 && b_valid});
      chk("b_ready", {63'b0, b_ready}, {63'b0, adv0 && a_valid});
      if (exp_valid) begin
        chk("result_data_u_lo", {32'b0, result_data}, {32'b0, lo_u(q[0].a, q[0].b)});
        chk("result_data_s_hi", {32'b0, sh_result_data}, {32'b0, hi_s(q[0].a, q[0].b)});
      end
      if (a_valid && b_valid && a_ready) dut_fires++;
      if (result_valid && result_ready) dut_pops++;
      if (exp_valid && result_ready) begin
        void'(q.pop_front());
        last_pop = cyc;
      end
      if (a_valid && b_valid && adv0) begin
        q.push_back('{a_data, b_data, cyc});
        m_fire = 1'b1;
      end
    end else begin
      q.delete();
      last_pop = -100;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    chk("rst_result_valid", {63'b0, result_valid}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_result_data", {32'b0, result_data}, 64'd0);
    chk("rst_sh_result_data", {32'b0, sh_result_data}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, f0, p0;
    logic [7:0] ra, rb;
    rst_n = 1'b0; a_valid = 0; b_valid = 0; result_ready = 1;
    a_data = '0; b_data = '0; v8 = 0; a8 = '0; b8 = '0;
    @(posedge clk); #1;
    step(); step();
    rst_n = 1'b1;
    check_reset_state();

    // Latency: 7*6 fires now, result 3 cycles later, busy for cycles 1..3 only.
    a_valid = 1; b_valid = 1; a_data = 7; b_data = 6;
    step();
    a_valid = 0; b_valid = 0;
    repeat (4) step();
    chk("lat_pop_count", 64'(dut_pops), 64'd1);

    // Back-to-back streaming of i*(i+1).
    p0 = dut_pops;
    for (int i = 0; i < 16; i++) begin
      a_valid = 1; b_valid = 1; a_data = i; b_data = i + 1;
      step();
    end
    a_valid = 0; b_valid = 0;
    repeat (S + 1) step();
    chk("stream_pop_count", 64'(dut_pops - p0), 64'd16);

    // Backpressure: only S pairs enter while the output is blocked.
    result_ready = 0; idx = 0; f0 = dut_fires; p0 = dut_pops;
    repeat (8) begin
      a_valid = (idx < 5); b_valid = (idx < 5);
      a_data = 32'h1000 + idx; b_data = 32'h30 + idx;
      step();
      if (m_fire) idx++;
    end
    chk("bp_accepted", 64'(dut_fires - f0), 64'd3);
    a_valid = 0; b_valid = 0; result_ready = 1;
    repeat (S + 2) step();
    chk("bp_drained", 64'(dut_pops - p0), 64'd3);

    // Join: A alone is never taken; one product once B arrives.
    a_valid = 1; b_valid = 0; a_data = 32'hFFFF_FFFF; b_data = 32'h8000_0001;
    f0 = dut_fires; p0 = dut_pops;
    repeat (4) step();
    chk("join_no_fire", 64'(dut_fires - f0), 64'd0);
    b_valid = 1;
    step();
    a_valid = 0; b_valid = 0;
    repeat (S + 2) step();
    chk("join_one_product", 64'(dut_pops - p0), 64'd1);

    // Reset with two entries in flight; nothing may emerge afterwards.
    a_valid = 1; b_valid = 1; a_data = 32'd11; b_data = 32'd13;
    step();
    a_data = 32'd17; b_data = 32'd19;
    step();
    a_valid = 0; b_valid = 0; rst_n = 0;
    step();
    rst_n = 1;
    check_reset_state();
    p0 = dut_pops;
    repeat (6) step();
    chk("reset_no_stale", 64'(dut_pops - p0), 64'd0);

    // 8-bit signedness and half selection.
    v8 = 1; a8 = 8'hFF; b8 = 8'h02;
    step();
    v8 = 0;
    step(); step();
    for (int k = 0; k < 4; k++) chk($sformatf("w8_valid_cfg%0d", k), {63'b0, rv8[k]}, 64'd1);
    chk("w8_u_lo", {56'b0, rd8[0]}, 64'hFE);
    chk("w8_u_hi", {56'b0, rd8[1]}, 64'h01);
    chk("w8_s_lo", {56'b0, rd8[2]}, 64'hFE);
    chk("w8_s_hi", {56'b0, rd8[3]}, 64'hFF);
    step();
    for (int t = 0; t < 12; t++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      v8 = 1; a8 = ra; b8 = rb;
      step();
      v8 = 0;
      step(); step();
      for (int k = 0; k < 4; k++) chk($sformatf("w8_rand_cfg%0d", k), {56'b0, rd8[k]}, {56'b0, ref8(k, ra, rb)});
      step();
    end

    // Randomised handshakes and operands against the queue model.
    for (int t = 0; t < 400; t++) begin
      a_valid = ($urandom_range(3) != 0);
      b_valid = ($urandom_range(3) != 0);
      result_ready = ($urandom_range(9) < 7);
      case ($urandom_range(3))
        0:       a_data = 32'hFFFF_FFFF;
        1:       a_data = 32'h8000_0000;
        default: a_data = $urandom;
      endcase
      b_data = ($urandom_range(4) == 0) ? 32'hFFFF_FFFF : $urandom;
      step();
    end
    a_valid = 0; b_valid = 0; result_ready = 1;
    repeat (S + 2) step();
    chk("final_empty", {63'b0, busy}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
